// File: rtl/uart_gpio_cmd_ctrl_if.sv
// Byte-stream, transmit handshake and GPIO bank signals of the UART/GPIO
// command controller, grouped so the host side and the controller share one bundle.
interface uart_gpio_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic [7:0] err_cnt;

    modport master (
        output rx_data, rx_valid, tx_busy, gpio_in,
        input  tx_data, tx_start, gpio_out, gpio_oe, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid, tx_busy, gpio_in,
        output tx_data, tx_start, gpio_out, gpio_oe, err_cnt
    );
endinterface

// File: rtl/uart_gpio_cmd_ctrl.sv
// Command sequencer: parses UART opcode/payload bytes, drives the GPIO output and
// direction registers, samples GPIO inputs and returns a one-byte reply.
module uart_gpio_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 43400,
    parameter logic [7:0]  OUT_RST     = 8'h00,
    parameter logic [7:0]  OE_RST      = 8'h00
) (
    input logic                 clk,
    input logic                 rst,
    uart_gpio_cmd_ctrl_if.slave bus
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_DIR   = 8'h44;
    localparam logic [7:0] OP_SET   = 8'h53;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARG1 = 3'd1,
        ST_ARG2 = 3'd2,
        ST_EXEC = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t           state_r;
    logic [7:0]       opcode_r;
    logic [7:0]       arg0_r;
    logic [7:0]       arg1_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [7:0]       sync1_r;
    logic [7:0]       sync2_r;
    logic [7:0]       gpio_out_r;
    logic [7:0]       gpio_oe_r;
    logic [7:0]       tx_data_r;
    logic             tx_start_r;
    logic [7:0]       err_cnt_r;

    logic             err_inc_s;
    logic             tmo_hit_s;

    function automatic logic is_known_op(input logic [7:0] op);
        case (op)
            OP_WRITE, OP_DIR, OP_SET, OP_READ: is_known_op = 1'b1;
            default:                           is_known_op = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = val + 8'd1;
        end
    endfunction

    // Error and timeout detection; a byte arriving on the timeout cycle wins.
    always_comb begin
        err_inc_s = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_r)
            ST_ARG1, ST_ARG2: begin
                if (!bus.rx_valid && (tmo_cnt_r == TMO_LAST)) begin
                    tmo_hit_s = 1'b1;
                    err_inc_s = 1'b1;
                end else begin
                    tmo_hit_s = 1'b0;
                    err_inc_s = 1'b0;
                end
            end
            ST_EXEC: err_inc_s = bus.rx_valid || !is_known_op(opcode_r);
            ST_RESP: err_inc_s = bus.rx_valid;
            default: err_inc_s = 1'b0;
        endcase
    end

    // Command FSM, GPIO registers, reply generation and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            opcode_r   <= 8'h00;
            arg0_r     <= 8'h00;
            arg1_r     <= 8'h00;
            tmo_cnt_r  <= '0;
            sync1_r    <= 8'h00;
            sync2_r    <= 8'h00;
            gpio_out_r <= OUT_RST;
            gpio_oe_r  <= OE_RST;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            err_cnt_r  <= 8'h00;
        end else begin
            sync1_r    <= bus.gpio_in;
            sync2_r    <= sync1_r;
            tx_start_r <= 1'b0;
            if (err_inc_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        opcode_r  <= bus.rx_data;
                        tmo_cnt_r <= '0;
                        if ((bus.rx_data == OP_READ) || !is_known_op(bus.rx_data)) begin
                            state_r <= ST_EXEC;
                        end else begin
                            state_r <= ST_ARG1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARG1: begin
                    if (bus.rx_valid) begin
                        arg0_r    <= bus.rx_data;
                        tmo_cnt_r <= '0;
                        state_r   <= (opcode_r == OP_SET) ? ST_ARG2 : ST_EXEC;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r <= '0;
                        state_r   <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                ST_ARG2: begin
                    if (bus.rx_valid) begin
                        arg1_r    <= bus.rx_data;
                        tmo_cnt_r <= '0;
                        state_r   <= ST_EXEC;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r <= '0;
                        state_r   <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                ST_EXEC: begin
                    // For 'S', arg0 is the bit mask and arg1 the new value.
                    case (opcode_r)
                        OP_WRITE: begin
                            gpio_out_r <= arg0_r;
                            tx_data_r  <= RSP_OK;
                        end
                        OP_DIR: begin
                            gpio_oe_r <= arg0_r;
                            tx_data_r <= RSP_OK;
                        end
                        OP_SET: begin
                            gpio_out_r <= (gpio_out_r & ~arg0_r) | (arg1_r & arg0_r);
                            tx_data_r  <= RSP_OK;
                        end
                        OP_READ: tx_data_r <= sync2_r;
                        default: tx_data_r <= RSP_ERR;
                    endcase
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (!bus.tx_busy) begin
                        tx_start_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.gpio_out = gpio_out_r;
    assign bus.gpio_oe  = gpio_oe_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_start = tx_start_r;
    assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_uart_gpio_cmd_ctrl.sv
// Directed bench for uart_gpio_cmd_ctrl: command vectors with hand-computed
// GPIO, reply, handshake, timeout and error-counter expectations.
module tb_uart_gpio_cmd_ctrl;

    localparam int unsigned T = 200;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   starts;
    int   st0;

    uart_gpio_cmd_ctrl_if bus ();

    uart_gpio_cmd_ctrl #(
        .TIMEOUT_CYC (T),
        .OUT_RST     (8'h00),
        .OE_RST      (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_start) starts <= starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},   {24'd0, bus.gpio_out}, 32'h00);
        chk({tag, "_oe"},    {24'd0, bus.gpio_oe},  32'h00);
        chk({tag, "_tx"},    {24'd0, bus.tx_data},  32'h00);
        chk({tag, "_start"}, {31'd0, bus.tx_start}, 32'h0);
        chk({tag, "_err"},   {24'd0, bus.err_cnt},  32'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        starts = 0;
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy = 1'b0;
        bus.gpio_in = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;
        @(negedge clk);

        // 1) write gpio_out
        st0 = starts;
        send_byte(8'h57);
        send_byte(8'hA5);
        chk("t1_out_pre", {24'd0, bus.gpio_out}, 32'h00);
        @(negedge clk);
        chk("t1_out", {24'd0, bus.gpio_out}, 32'hA5);
        chk("t1_tx", {24'd0, bus.tx_data}, 32'h4B);
        chk("t1_start_early", {31'd0, bus.tx_start}, 32'h0);
        @(negedge clk);
        chk("t1_start", {31'd0, bus.tx_start}, 32'h1);
        @(negedge clk);
        chk("t1_start_end", {31'd0, bus.tx_start}, 32'h0);
        chk("t1_pulses", starts - st0, 32'd1);

        // 2) masked set: (F0 & ~3C) | (0F & 3C) = CC
        send_byte(8'h57);
        send_byte(8'hF0);
        repeat (2) @(negedge clk);
        send_byte(8'h53);
        send_byte(8'h3C);
        send_byte(8'h0F);
        @(negedge clk);
        chk("t2_out", {24'd0, bus.gpio_out}, 32'hCC);
        chk("t2_oe", {24'd0, bus.gpio_oe}, 32'h00);
        chk("t2_tx", {24'd0, bus.tx_data}, 32'h4B);
        @(negedge clk);
        chk("t2_start", {31'd0, bus.tx_start}, 32'h1);

        // 3) read synced gpio_in with transmitter held busy
        bus.gpio_in = 8'h5A;
        bus.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        st0 = starts;
        send_byte(8'h52);
        @(negedge clk);
        chk("t3_tx", {24'd0, bus.tx_data}, 32'h5A);
        repeat (100) @(negedge clk);
        chk("t3_busy_nostart", starts - st0, 32'd0);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("t3_start", {31'd0, bus.tx_start}, 32'h1);
        repeat (3) @(negedge clk);
        chk("t3_pulses", starts - st0, 32'd1);

        // 4) inter-byte timeout, then recovery, then byte on the timeout cycle
        st0 = starts;
        send_byte(8'h44);
        repeat (T - 1) @(negedge clk);
        chk("t4_err_pre", {24'd0, bus.err_cnt}, 32'h00);
        @(negedge clk);
        chk("t4_err", {24'd0, bus.err_cnt}, 32'h01);
        chk("t4_oe", {24'd0, bus.gpio_oe}, 32'h00);
        repeat (2) @(negedge clk);
        chk("t4_nostart", starts - st0, 32'd0);
        send_byte(8'h44);
        send_byte(8'hFF);
        @(negedge clk);
        chk("t4_oe_ff", {24'd0, bus.gpio_oe}, 32'hFF);
        @(negedge clk);
        send_byte(8'h44);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h0F);
        @(negedge clk);
        chk("t4_race_oe", {24'd0, bus.gpio_oe}, 32'h0F);
        chk("t4_race_err", {24'd0, bus.err_cnt}, 32'h01);
        @(negedge clk);
        chk("t4_race_start", {31'd0, bus.tx_start}, 32'h1);

        // 5) unknown opcode and overruns
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.tx_busy = 1'b1;
        send_byte(8'h11);
        @(negedge clk);
        chk("t5_tx", {24'd0, bus.tx_data}, 32'h3F);
        chk("t5_err1", {24'd0, bus.err_cnt}, 32'h01);
        send_byte(8'h77);
        chk("t5_err2", {24'd0, bus.err_cnt}, 32'h02);
        chk("t5_out", {24'd0, bus.gpio_out}, 32'h00);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("t5_start", {31'd0, bus.tx_start}, 32'h1);
        send_byte(8'h57);
        send_byte(8'h33);
        @(negedge clk);
        chk("t5_after_out", {24'd0, bus.gpio_out}, 32'h33);
        @(negedge clk);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("t5_once", {24'd0, bus.err_cnt}, 32'h03);
        repeat (2) @(negedge clk);

        // 6) reset mid-command, then error counter saturation
        send_byte(8'h53);
        send_byte(8'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("t6_rst");
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hC3);
            repeat (2) @(negedge clk);
            if (i == 253) chk("t6_err_fe", {24'd0, bus.err_cnt}, 32'hFE);
            if (i == 254) chk("t6_err_ff", {24'd0, bus.err_cnt}, 32'hFF);
        end
        chk("t6_err_sat", {24'd0, bus.err_cnt}, 32'hFF);
        chk("t6_out", {24'd0, bus.gpio_out}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
